// File: rtl/match_collector_if.sv
`default_nettype none
// ============================================================================
// match_collector_if : lane-array input and result bus of match_collector
// Rev 1.0 - initial release
// ============================================================================
interface match_collector_if #(
    parameter int LANES = 32,
    parameter int POS_W = 9,
    parameter int ITE_W = 3
);
    logic                         i_start;
    logic [ITE_W-1:0]             i_ite;
    logic [LANES-1:0]             i_valid;
    logic [LANES-1:0][POS_W-1:0]  i_pos;

    logic                         o_busy;
    logic                         o_done;
    logic [8:0]                   o_count;
    logic [16:0]                  o_sum;
    logic [POS_W-1:0]             o_min;
    logic [POS_W-1:0]             o_max;
    logic [POS_W-1:0]             o_mean;
    logic                         o_empty;

    modport master (
        output i_start, i_ite, i_valid, i_pos,
        input  o_busy, o_done, o_count, o_sum, o_min, o_max, o_mean, o_empty
    );

    modport slave (
        input  i_start, i_ite, i_valid, i_pos,
        output o_busy, o_done, o_count, o_sum, o_min, o_max, o_mean, o_empty
    );
endinterface
`default_nettype wire

// File: rtl/match_collector.sv
`default_nettype none
// ============================================================================
// match_collector : scans match lanes one per cycle, accumulates count/sum/
//                   min/max across passes and computes floor(sum/count).
// Rev 1.0 - initial release
// ============================================================================
module match_collector #(
    parameter int LANES = 32,
    parameter int POS_W = 9,
    parameter int ITE_W = 3
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    match_collector_if.slave bus
);

    localparam int c_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_CNT_W  = 9;
    localparam int c_SUM_W  = 17;
    localparam int c_STEP_W = 5;
    localparam logic [c_IDX_W-1:0]  c_LAST_LANE = c_IDX_W'(LANES - 1);
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(c_SUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LANES-1:0]            r_valid;
    logic [LANES-1:0][POS_W-1:0] r_pos;
    logic [c_IDX_W-1:0]          r_idx;

    logic [c_CNT_W-1:0]          r_count;
    logic [c_SUM_W-1:0]          r_sum;
    logic [POS_W-1:0]            r_min;
    logic [POS_W-1:0]            r_max;

    logic [c_STEP_W-1:0]         r_step;
    logic [c_CNT_W-1:0]          r_rem;
    logic [POS_W-1:0]            r_quo;

    logic                        r_done;
    logic [c_CNT_W-1:0]          r_res_count;
    logic [c_SUM_W-1:0]          r_res_sum;
    logic [POS_W-1:0]            r_res_min;
    logic [POS_W-1:0]            r_res_max;
    logic [POS_W-1:0]            r_res_mean;
    logic                        r_res_empty;

    logic                        w_cur_valid;
    logic [POS_W-1:0]            w_cur_pos;
    logic                        w_div_bit;
    logic [c_CNT_W:0]            w_rem_sh;
    logic                        w_ge;
    logic [c_CNT_W-1:0]          w_diff;

    assign w_cur_valid = r_valid[r_idx];
    assign w_cur_pos   = r_pos[r_idx];

    // Dividend bits are taken MSB first straight from the settled sum.
    assign w_div_bit = r_sum[c_LAST_STEP - r_step];
    assign w_rem_sh  = {r_rem, w_div_bit};
    assign w_ge      = (w_rem_sh >= {1'b0, r_count});
    assign w_diff    = w_rem_sh[c_CNT_W-1:0] - r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.i_start)               w_next = S_SCAN;
            S_SCAN: if (r_idx == c_LAST_LANE)      w_next = S_DIV;
            S_DIV:  if (r_step == c_LAST_STEP)     w_next = S_DONE;
            S_DONE:                                w_next = S_IDLE;
            default:                               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid     <= '0;
            r_pos       <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_min       <= '1;
            r_max       <= '0;
            r_step      <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_done      <= 1'b0;
            r_res_count <= '0;
            r_res_sum   <= '0;
            r_res_min   <= '0;
            r_res_max   <= '0;
            r_res_mean  <= '0;
            r_res_empty <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_valid <= bus.i_valid;
                        r_pos   <= bus.i_pos;
                        r_idx   <= '0;
                        if (bus.i_ite == ITE_W'(0)) begin
                            r_count <= '0;
                            r_sum   <= '0;
                            r_min   <= '1;
                            r_max   <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_cur_valid) begin
                        r_count <= r_count + c_CNT_W'(1);
                        r_sum   <= r_sum + c_SUM_W'(w_cur_pos);
                        if (w_cur_pos < r_min) r_min <= w_cur_pos;
                        if (w_cur_pos > r_max) r_max <= w_cur_pos;
                    end
                    r_idx  <= r_idx + c_IDX_W'(1);
                    r_step <= '0;
                    r_rem  <= '0;
                    r_quo  <= '0;
                end
                S_DIV: begin
                    r_rem  <= w_ge ? w_diff : w_rem_sh[c_CNT_W-1:0];
                    r_quo  <= {r_quo[POS_W-2:0], w_ge};
                    r_step <= r_step + c_STEP_W'(1);
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_res_count <= r_count;
                    r_res_sum   <= r_sum;
                    // An empty frame reports zeros rather than the min/max sentinels.
                    if (r_count == '0) begin
                        r_res_min   <= '0;
                        r_res_max   <= '0;
                        r_res_mean  <= '0;
                        r_res_empty <= 1'b1;
                    end else begin
                        r_res_min   <= r_min;
                        r_res_max   <= r_max;
                        r_res_mean  <= r_quo;
                        r_res_empty <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy  = (r_state != S_IDLE);
    assign bus.o_done  = r_done;
    assign bus.o_count = r_res_count;
    assign bus.o_sum   = r_res_sum;
    assign bus.o_min   = r_res_min;
    assign bus.o_max   = r_res_max;
    assign bus.o_mean  = r_res_mean;
    assign bus.o_empty = r_res_empty;

endmodule
`default_nettype wire

// File: tb/tb_match_collector.sv
`default_nettype none
// ============================================================================
// tb_match_collector : directed and random passes against a frame-level model
// Rev 1.0 - initial release
// ============================================================================
module tb_match_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    match_collector_if #(.LANES(32), .POS_W(9), .ITE_W(3)) bus ();

    match_collector #(.LANES(32), .POS_W(9), .ITE_W(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: every valid position seen since the last ite==0 pass.
    int frame_q[$];
    int ex_count, ex_sum, ex_min, ex_max, ex_mean, ex_empty;
    int prev_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input logic [31:0] v, input logic [31:0][8:0] p, input int ite);
        if (ite == 0) frame_q.delete();
        for (int i = 0; i < 32; i++) if (v[i]) frame_q.push_back(int'(p[i]));
        ex_count = frame_q.size();
        ex_sum = 0;
        ex_min = 0;
        ex_max = 0;
        foreach (frame_q[j]) begin
            ex_sum += frame_q[j];
            if (j == 0 || frame_q[j] < ex_min) ex_min = frame_q[j];
            if (j == 0 || frame_q[j] > ex_max) ex_max = frame_q[j];
        end
        ex_empty = (ex_count == 0) ? 1 : 0;
        ex_mean  = (ex_count == 0) ? 0 : ex_sum / ex_count;
    endtask

    // Drives one pass; optionally fires a second start at negedge 'intr'.
    task automatic do_pass(input logic [31:0] v, input logic [31:0][8:0] p, input int ite,
                           input int intr, input logic [31:0] v2, input logic [31:0][8:0] p2);
        int n;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_valid = v;
        bus.i_pos   = p;
        bus.i_ite   = 3'(ite);
        @(negedge clk);
        bus.i_start = 1'b0;
        chk("busy_after_start", 32'(bus.o_busy), 1);
        n = 0;
        while (!bus.o_done && n < 60) begin
            @(negedge clk);
            n++;
            if (n == intr) begin
                bus.i_start = 1'b1;
                bus.i_valid = v2;
                bus.i_pos   = p2;
                bus.i_ite   = 3'd0;
            end else if (n == intr + 1) begin
                bus.i_start = 1'b0;
            end
            if (n == 25) chk("hold_count", 32'(bus.o_count), 32'(prev_count));
        end
        bus.i_start = 1'b0;
        model_apply(v, p, ite);
        chk("latency", 32'(n), 50);
        chk("busy_at_done", 32'(bus.o_busy), 0);
        chk("count", 32'(bus.o_count), 32'(ex_count));
        chk("sum", 32'(bus.o_sum), 32'(ex_sum));
        chk("min", 32'(bus.o_min), 32'(ex_min));
        chk("max", 32'(bus.o_max), 32'(ex_max));
        chk("mean", 32'(bus.o_mean), 32'(ex_mean));
        chk("empty", 32'(bus.o_empty), 32'(ex_empty));
        prev_count = ex_count;
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.o_done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]       v_all;
        logic [31:0]       v_none;
        logic [31:0][8:0]  p2i, p3i, p_zero, p_last, p_100, p_rand;
        int                fp;
        int                ite;
        int                dones;

        v_all  = '1;
        v_none = '0;
        for (int i = 0; i < 32; i++) begin
            p2i[i]    = 9'(2 * i);
            p3i[i]    = 9'(3 * i);
            p_zero[i] = 9'd0;
            p_100[i]  = 9'd100;
            p_last[i] = 9'(i);
        end
        p_last[31] = 9'd511;

        bus.i_start = 1'b0;
        bus.i_ite   = '0;
        bus.i_valid = '0;
        bus.i_pos   = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_done", 32'(bus.o_done), 0);
        chk("rst_count", 32'(bus.o_count), 0);
        chk("rst_sum", 32'(bus.o_sum), 0);
        chk("rst_min", 32'(bus.o_min), 0);
        chk("rst_max", 32'(bus.o_max), 0);
        chk("rst_mean", 32'(bus.o_mean), 0);
        chk("rst_empty", 32'(bus.o_empty), 1);
        rst = 1'b0;
        @(negedge clk);

        // Two-pass frame, empty frame, single top lane
        do_pass(v_all, p2i, 0, -10, v_none, p_zero);
        do_pass(v_all, p3i, 1, -10, v_none, p_zero);
        do_pass(v_none, p2i, 0, -10, v_none, p_zero);
        do_pass(32'h8000_0000, p_last, 0, -10, v_none, p_zero);

        // Start during SCAN is ignored
        do_pass(v_all, p2i, 0, 11, v_all, p_100);

        // Asynchronous reset in the middle of SCAN
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_valid = v_all;
        bus.i_pos   = p2i;
        bus.i_ite   = 3'd0;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (11) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.o_busy), 0);
        chk("arst_done", 32'(bus.o_done), 0);
        chk("arst_count", 32'(bus.o_count), 0);
        chk("arst_sum", 32'(bus.o_sum), 0);
        chk("arst_empty", 32'(bus.o_empty), 1);
        @(negedge clk);
        rst = 1'b0;
        frame_q.delete();
        prev_count = 0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        chk("aborted_no_done", 32'(dones), 0);
        do_pass(v_all, p2i, 0, -10, v_none, p_zero);

        // Random passes, at most 8 per frame
        fp = 1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 32; i++) p_rand[i] = 9'($urandom_range(0, 511));
            case ($urandom_range(0, 3))
                0:       v_none = '0;
                1:       v_none = $urandom & $urandom & $urandom;
                default: v_none = $urandom;
            endcase
            if (fp >= 8 || $urandom_range(0, 3) == 0) begin
                ite = 0;
                fp = 1;
            end else begin
                ite = int'($urandom_range(1, 7));
                fp++;
            end
            do_pass(v_none, p_rand, ite, -10, '0, p_zero);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_collector.md
MATCH_COLLECTOR -- requirements
Module: match_collector

Interface
REQ-001 Parameter LANES, default 32, number of match lanes presented per pass.
REQ-002 Parameter POS_W, default 9, width of each lane position.
REQ-003 Parameter ITE_W, default 3, width of the pass index.
REQ-004 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-005 i_rst  in  1  reset; asynchronous, active-high.
REQ-006 i_start  in  1  one-cycle pulse: lane arrays valid this cycle (matcher finish strobe).
REQ-007 i_ite  in  ITE_W  pass index; 0 = first pass of a frame.
REQ-008 i_valid  in  LANES x 1  per-lane match flag.
REQ-009 i_pos  in  LANES x POS_W  per-lane match position.
REQ-010 o_busy  out  1  high in every state except IDLE.
REQ-011 o_done  out  1  one-cycle pulse: result outputs updated.
REQ-012 o_count  out  9  accumulated valid-lane count.
REQ-013 o_sum  out  17  accumulated sum of valid positions.
REQ-014 o_min  out  POS_W  minimum valid position.
REQ-015 o_max  out  POS_W  maximum valid position.
REQ-016 o_mean  out  POS_W  floor(o_sum / o_count).
REQ-017 o_empty  out  1  high when o_count == 0.

Function
REQ-018 States: IDLE, SCAN, DIV, DONE; reset state IDLE.
REQ-019 In IDLE, i_start high at edge T shall latch all i_valid/i_pos into internal registers and enter SCAN; in every other state i_start is ignored.
REQ-020 i_ite == 0 at the accepting edge shall clear the count, sum, min and max accumulators before lane 0 is processed; i_ite != 0 accumulates onto the previous pass.
REQ-021 SCAN: one lane per cycle, lane k at edge T+1+k, k = 0..LANES-1; leave for DIV at edge T+LANES.
REQ-022 Valid lane: count += 1; sum += pos (zero-extended to 17 bits); min = smaller, max = larger; invalid lane changes nothing.
REQ-023 Min accumulator clears to all-ones and max to zero; on the first valid lane both take that lane's pos.
REQ-024 DIV: restoring divide of sum by count, 17 iterations, one per edge, T+LANES+1 .. T+LANES+17; then enter DONE.
REQ-025 Count == 0: divider skipped in value (quotient forced to 0), DIV still takes 17 cycles so latency is constant.
REQ-026 DONE edge (T+LANES+18): o_count, o_sum, o_min, o_max, o_mean, o_empty register together; o_done high exactly for the following cycle; next state IDLE.
REQ-027 When count == 0: o_min = 0, o_max = 0, o_mean = 0, o_empty = 1.
REQ-028 Latency with LANES = 32: o_done rises 50 edges after the accepting edge; next start accepted from edge T+51.
REQ-029 Result outputs hold their values between o_done pulses; they never show partial results.
REQ-030 Count saturates at neither width: 8 passes x 32 lanes = 256 and 256 x 511 = 130816 fit in 9 and 17 bits; passes beyond 8 without an i_ite == 0 clear wrap modulo width (undefined use).

Reset
REQ-031 i_rst high shall force within the same cycle: state IDLE, o_busy 0, o_done 0, all result outputs 0 except o_empty 1, accumulators cleared, latched lanes cleared.
REQ-032 Reset asserted mid-SCAN or mid-DIV aborts the pass; no o_done is produced for it.
REQ-033 After i_rst falls, the first i_start is accepted normally.

Verification
REQ-034 All lanes valid, pos[i] = 2i, i_ite = 0 -> o_count 32, o_sum 992, o_min 0, o_max 62, o_mean 31, o_empty 0, o_done 50 edges after start.
REQ-035 Same frame, second pass i_ite = 1, pos[i] = 3i, all valid -> o_count 64, o_sum 2480, o_min 0, o_max 93, o_mean 38.
REQ-036 All lanes invalid, i_ite = 0 -> o_count 0, o_sum 0, o_min 0, o_max 0, o_mean 0, o_empty 1, o_done still at +50.
REQ-037 Only lane 31 valid, pos 511 -> o_count 1, o_sum 511, o_min = o_max = o_mean = 511.
REQ-038 Second i_start 10 cycles into SCAN with different data -> ignored; results match the first data; exactly one o_done.
REQ-039 i_rst pulsed at SCAN lane 10 -> o_busy 0 immediately, outputs at reset values, no o_done; a following start with REQ-034 data gives the REQ-034 results.
